// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV32I multicycle control unit: ALU operation
// codes (also used by the ALU), major opcodes, FSM states and mux selects.
package ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_XOR  = 4'b1010;
  localparam logic [3:0] ALU_BGE  = 4'b1011;
  localparam logic [3:0] ALU_GEU  = 4'b1101;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_LUI, S_JAL, S_JALR, S_BRANCH, S_TRAP
  } state_t;

  // Which decode table the ALU decoder applies in the current state.
  typedef enum logic [1:0] {CLS_ADD, CLS_RTYPE, CLS_ITYPE, CLS_BRANCH} alu_class_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps (state class, funct3, funct7b5) to the ALU operation code and tells
// the FSM whether a branch is taken on zero (BEQ) or on non-zero (others).
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic [3:0]  alu_control,
  output logic        branch_if_zero
);

  // ALU op selection; ADD whenever the state is not an execute/branch state.
  always_comb begin
    alu_control    = ALU_ADD;
    branch_if_zero = 1'b0;
    case (alu_class)
      CLS_RTYPE, CLS_ITYPE: begin
        case (funct3)
          3'b000:  alu_control = (alu_class == CLS_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
      CLS_BRANCH: begin
        case (funct3)
          3'b000: begin
            alu_control    = ALU_SUB;
            branch_if_zero = 1'b1;
          end
          3'b100:  alu_control = ALU_SLT;
          3'b101:  alu_control = ALU_BGE;
          3'b110:  alu_control = ALU_SLTU;
          3'b111:  alu_control = ALU_GEU;
          // BNE, plus the 010/011 encodings that never reach BRANCH.
          default: alu_control = ALU_SUB;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle RV32I control FSM (Moore, except the FETCH/BRANCH enables and
// imm_src). Memory states wait on mem_ready, so CPI varies.
module control_unit
  import ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [3:0] alu_control,
  output logic       illegal
);

  state_t     state_q, state_d;
  alu_class_t alu_class;
  logic       branch_if_zero;
  logic       take;
  state_t     bad_instr_state;

  assign bad_instr_state = ILLEGAL_HALT ? S_TRAP : S_FETCH;
  assign take            = branch_if_zero ? zero : ~zero;

  alu_decoder u_alu_decoder (
    .alu_class      (alu_class),
    .funct3         (funct3),
    .funct7b5       (funct7b5),
    .alu_control    (alu_control),
    .branch_if_zero (branch_if_zero)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Immediate format depends only on the opcode, independent of state.
  always_comb begin
    imm_src = IMM_I;
    case (opcode)
      OP_STORE:         imm_src = IMM_S;
      OP_BRANCH:        imm_src = IMM_B;
      OP_JAL:           imm_src = IMM_J;
      OP_LUI, OP_AUIPC: imm_src = IMM_U;
      default:          imm_src = IMM_I;
    endcase
  end

  // Next state and datapath controls for the current state.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = ADR_PC;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_class  = CLS_ADD;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU;
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? bad_instr_state : S_BRANCH;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_ALUWB;
          default:           state_d = bad_instr_state;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = ADR_ALUOUT;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = ADR_ALUOUT;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_class = CLS_RTYPE;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_class = CLS_ITYPE;
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRC_A_ZERO;
        alu_src_b = SRC_B_IMM;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_JALR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        state_d   = S_JAL;
      end
      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_class  = CLS_BRANCH;
        result_src = RES_ALUOUT;
        pc_write   = take;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    // Keep every enable quiet while reset is held, even in FETCH.
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle control unit for the RV32I core: a Moore FSM that sequences fetch, decode, execute, memory and writeback, plus a decoder that produces the 4-bit ALU operation code. It sits beside the ALU, register file and memory interface and drives every mux select, write enable and `alu_control` in the datapath. Memory accesses use a ready handshake, so an instruction takes a variable number of cycles.

## Interface
- `ILLEGAL_HALT`, default 1: 1 = illegal instruction parks the FSM in TRAP; 0 = the instruction is dropped and the FSM returns to FETCH.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  7  instruction[6:0], from the instruction register.
- `funct3`  in  3  instruction[14:12].
- `funct7b5`  in  1  instruction[30].
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory has completed the current access.
- `pc_write`  out  1  PC load enable.
- `ir_write`  out  1  instruction-register and old-PC load enable.
- `adr_src`  out  1  memory address source: 0 = PC, 1 = ALU-out register.
- `mem_write`  out  1  memory write request.
- `reg_write`  out  1  register-file write enable.
- `result_src`  out  2  result bus source: 00 = ALU-out register, 01 = read data, 10 = ALU result.
- `alu_src_a`  out  2  ALU A operand: 00 = PC, 01 = old PC, 10 = rs1, 11 = zero.
- `alu_src_b`  out  2  ALU B operand: 00 = rs2, 01 = immediate, 10 = constant 4.
- `imm_src`  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U. Decoded combinationally from `opcode` in every state.
- `alu_control`  out  4  ALU operation code.
- `illegal`  out  1  high while in TRAP.

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SRA 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, XOR 1010, BGE 1011, GEU 1101, SLTU 1111.
- Defaults: every output is 0 unless listed; `alu_control` defaults to ADD.
- FETCH: a=00, b=10, result_src=10, adr_src=0. `ir_write` and `pc_write` equal `mem_ready`. Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE: a=01, b=01, ADD (computes the branch/JAL target and AUIPC value). Next state by opcode:
  - 0000011 / 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BRANCH
  - 0110111 → LUI
  - 0010111 → ALUWB
  - Anything else, or a branch with funct3 010/011 → TRAP (or FETCH if `ILLEGAL_HALT`=0).
- MEMADR: a=10, b=01, ADD. Go to MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adr_src=1. Hold until `mem_ready`, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1. Go to FETCH.
- MEMWRITE: adr_src=1, `mem_write`=1, held until `mem_ready`. Go to FETCH.
- EXECR: a=10, b=00, ALU op from decode. EXECI: a=10, b=01, ALU op from decode. Both go to ALUWB.
- LUI: a=11, b=01, ADD. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH.
- JALR: a=10, b=01, ADD (rs1+imm into the ALU-out register). Go to JAL.
- JAL: a=01, b=10, ADD, result_src=00, pc_write=1 (PC ← target, ALU-out ← old PC+4). Go to ALUWB.
- BRANCH: a=10, b=00, result_src=00, pc_write = taken. Go to FETCH.
- TRAP: all enables 0, `illegal`=1. Left only by reset.
- EXEC decode by funct3:
  - 000: ADD, or SUB when R-type and funct7b5=1
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR
  - 101: SRL, or SRA when funct7b5=1
  - 110 OR, 111 AND
  - For I-type, funct7b5 selects only between SRL and SRA.
- Branch decode (ALU code, take condition):
  - 000 BEQ: SUB, `zero`
  - 001 BNE: SUB, ~`zero`
  - 100 BLT: SLT, ~`zero`
  - 101 BGE: BGE, ~`zero`
  - 110 BLTU: SLTU, ~`zero`
  - 111 BGEU: GEU, ~`zero`

## Timing
- Outputs are a function of state only, except three combinational terms: FETCH `pc_write`/`ir_write` (gated by `mem_ready`), BRANCH `pc_write` (uses `zero`), and `imm_src` (from `opcode`).
- While `rst` is high: state = FETCH, and `pc_write`, `ir_write`, `mem_write`, `reg_write`, `illegal` are forced to 0.
- Reset mid-instruction aborts it; the first cycle after release is FETCH.
- Cycles per instruction with `mem_ready` tied high: AUIPC 3, branch 3, R/I-type 4, LUI 4, JAL 4, store 4, load 5, JALR 5. Each cycle `mem_ready` is low in FETCH, MEMREAD or MEMWRITE adds one cycle.

## Structure
- `ctrl_pkg` holds the ALU code localparams, opcode constants, state encoding, and mux-select encodings. The ALU shares the ALU codes from this package.
- One combinational sub-module, `alu_decoder`: inputs state class, funct3 and funct7b5; outputs `alu_control` and the branch take condition.

## Test plan
- Reset asserted in MEMREAD with `mem_ready` low → next cycle FETCH, all write enables 0.
- `add x3,x1,x2` (0x002081B3), `mem_ready`=1 → states FETCH, DECODE, EXECR, ALUWB; `alu_control`=0010 in EXECR; reg_write only in ALUWB.
- `sub` (funct7b5=1), `srai`, and `addi` with instr[30]=1 → EXECR/EXECI `alu_control` = 0110, 0011, 0010.
- `lw` with `mem_ready` low for 3 cycles in MEMREAD → MEMREAD held 4 cycles, adr_src=1 throughout, then MEMWB with result_src=01.
- `bne` with `zero`=1, then `bge` with `zero`=0 → BRANCH `pc_write` 0 for the first and 1 for the second; `alu_control` 0110 then 1011.
- opcode 0x7F with `ILLEGAL_HALT`=1 → TRAP, `illegal`=1 held for 10+ cycles; with `ILLEGAL_HALT`=0 → back to FETCH after DECODE.
